id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath width.
REQ-002 Parameter RAW, default 5, register-index width.
REQ-003 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_i  input  1  synchronous, active-low reset, sampled on clk_i rising edge.
REQ-005 stall_i  input  1  hold all stage contents (external freeze).
REQ-006 flush_i  input  1  replace next loaded entry with a bubble.
REQ-007 valid_i  input  1  ID holds a real instruction.
REQ-008 RS1data_i  input  XLEN  register-file read data 1.
REQ-009 RS2data_i  input  XLEN  register-file read data 2.
REQ-010 imm_i  input  XLEN  sign-extended immediate.
REQ-011 funct_i  input  10  {funct7,funct3} for ALU control.
REQ-012 Rs1_i  input  RAW  source index 1 of ID instruction.
REQ-013 Rs2_i  input  RAW  source index 2 of ID instruction.
REQ-014 Rd_i  input  RAW  destination index of ID instruction.
REQ-015 ctrl_i  input  8  {RegWrite,MemtoReg,MemRead,MemWrite,ALUSrc,ALUOp[1:0],0}.
REQ-016 valid_o  output  1  EX entry is a real instruction.
REQ-017 RS1data_o, RS2data_o, imm_o  output  XLEN each  registered copies of inputs.
REQ-018 funct_o  output  10  registered funct.
REQ-019 Rs1_o, Rs2_o, Rd_o  output  RAW each  registered indices, fed to forwarding logic.
REQ-020 ctrl_o  output  8  registered control bundle, same bit order as ctrl_i.
REQ-021 hazard_o  output  1  load-use hazard; ID/IF must hold and PC must not advance.

Function
REQ-022 Update priority per edge SHALL be: reset > stall_i hold > flush_i bubble > hazard bubble > normal load.
REQ-023 Normal load SHALL capture every input into its output register; latency exactly one cycle.
REQ-024 A bubble SHALL set valid_o=0, ctrl_o=8'h00, Rs1_o=Rs2_o=Rd_o=0; data fields SHALL be don't-care but driven 0.
REQ-025 valid_i=0 on a normal load SHALL produce a bubble.
REQ-026 Loaded ctrl_o[7] (RegWrite) SHALL be forced 0 when Rd_i==0, so no x0 write is ever forwarded.
REQ-027 stall_i=1 SHALL hold every output register unchanged, including during flush_i or hazard.
REQ-028 hazard_o SHALL be combinational: ctrl_o[5] & valid_o & (Rd_o!=0) & ((Rd_o==Rs1_i)|(Rd_o==Rs2_i)).
REQ-029 hazard_o SHALL be valid regardless of stall_i; bubble after a load SHALL clear it next cycle (exactly one stall cycle per load-use pair).
REQ-030 Simultaneous flush_i and hazard SHALL yield a single bubble.

Reset
REQ-031 rst_i=0 at an edge SHALL clear all registered outputs to 0 (valid_o=0, ctrl_o=8'h00), hence hazard_o=0; reset mid-stall or mid-hazard SHALL discard the entry.

Configuration
REQ-032 Macro ID_EX_LOAD_USE_DETECT_EN defined: REQ-028/029 active; undefined: hazard_o tied 0, hazard bubbles never inserted, all else unchanged.

Structure
REQ-033 Shared package pipe_pkg SHALL hold ctrl bit-position constants, ALUOp encodings, CTRL_NOP=8'h00 and XLEN/RAW defaults.
REQ-034 Load-use comparator SHALL be sub-module load_use_detect, instantiated only under ID_EX_LOAD_USE_DETECT_EN.

Verification
REQ-035 Normal: ctrl_i=8'h88, Rd_i=5, RS1data_i=32'h1234 -> next cycle ctrl_o=8'h88, Rd_o=5, RS1data_o=32'h1234, valid_o=1.
REQ-036 Load-use: EX holds lw Rd_o=7, ID Rs2_i=7 -> hazard_o=1; next cycle ctrl_o=0, valid_o=0, hazard_o=0.
REQ-037 x0: Rd_i=0, ctrl_i=8'h88 -> ctrl_o=8'h08; lw with Rd_o=0 and Rs1_i=0 -> hazard_o=0.
REQ-038 Stall: stall_i=1 for 3 cycles with flush_i=1 -> outputs identical across all 3 cycles; hazard_o still tracks Rs1_i.
REQ-039 Reset: rst_i=0 one edge while a lw is held -> valid_o=0, ctrl_o=0, hazard_o=0; rst_i=0 without an edge changes nothing.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: control-bundle bit positions, ALUOp codes and width defaults.
package pipe_pkg;

    localparam int unsigned XLEN_DEF = 32;
    localparam int unsigned RAW_DEF  = 5;

    // ctrl bundle layout: {RegWrite,MemtoReg,MemRead,MemWrite,ALUSrc,ALUOp[1:0],0}
    localparam int unsigned CTRL_REGWRITE = 7;
    localparam int unsigned CTRL_MEMTOREG = 6;
    localparam int unsigned CTRL_MEMREAD  = 5;
    localparam int unsigned CTRL_MEMWRITE = 4;
    localparam int unsigned CTRL_ALUSRC   = 3;
    localparam int unsigned CTRL_ALUOP_HI = 2;
    localparam int unsigned CTRL_ALUOP_LO = 1;

    localparam logic [7:0] CTRL_NOP = 8'h00;

    typedef enum logic [1:0] {
        ALUOP_ADD    = 2'b00,
        ALUOP_BRANCH = 2'b01,
        ALUOP_FUNCT  = 2'b10,
        ALUOP_IMM    = 2'b11
    } aluop_e;

    typedef enum logic [1:0] {
        LOAD_HOLD,
        LOAD_BUBBLE,
        LOAD_NORMAL
    } load_sel_e;

endpackage

// File: rtl/load_use_detect.sv
// Load-use comparator: flags an EX-stage load whose destination is read by the ID instruction.
module load_use_detect #(
    parameter int unsigned RAW = 5
) (
    input  logic           mem_read_i,
    input  logic           valid_i,
    input  logic [RAW-1:0] rd_i,
    input  logic [RAW-1:0] rs1_i,
    input  logic [RAW-1:0] rs2_i,
    output logic           hazard_o
);

    always_comb begin
        hazard_o = mem_read_i && valid_i && (rd_i != '0) &&
                   ((rd_i == rs1_i) || (rd_i == rs2_i));
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with stall, flush and bubble insertion.
// Optional load-use hazard detection enabled by ID_EX_LOAD_USE_DETECT_EN.
module id_ex_stage
    import pipe_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF,
    parameter int unsigned RAW  = RAW_DEF
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic            valid_i,
    input  logic [XLEN-1:0] RS1data_i,
    input  logic [XLEN-1:0] RS2data_i,
    input  logic [XLEN-1:0] imm_i,
    input  logic [9:0]      funct_i,
    input  logic [RAW-1:0]  Rs1_i,
    input  logic [RAW-1:0]  Rs2_i,
    input  logic [RAW-1:0]  Rd_i,
    input  logic [7:0]      ctrl_i,
    output logic            valid_o,
    output logic [XLEN-1:0] RS1data_o,
    output logic [XLEN-1:0] RS2data_o,
    output logic [XLEN-1:0] imm_o,
    output logic [9:0]      funct_o,
    output logic [RAW-1:0]  Rs1_o,
    output logic [RAW-1:0]  Rs2_o,
    output logic [RAW-1:0]  Rd_o,
    output logic [7:0]      ctrl_o,
    output logic            hazard_o
);

    logic            valid_q,  valid_d;
    logic [XLEN-1:0] rs1data_q, rs1data_d;
    logic [XLEN-1:0] rs2data_q, rs2data_d;
    logic [XLEN-1:0] imm_q,    imm_d;
    logic [9:0]      funct_q,  funct_d;
    logic [RAW-1:0]  rs1_q,    rs1_d;
    logic [RAW-1:0]  rs2_q,    rs2_d;
    logic [RAW-1:0]  rd_q,     rd_d;
    logic [7:0]      ctrl_q,   ctrl_d;
    logic            hazard;
    load_sel_e       load_sel;

`ifdef ID_EX_LOAD_USE_DETECT_EN
    load_use_detect #(
        .RAW(RAW)
    ) u_load_use_detect (
        .mem_read_i(ctrl_q[CTRL_MEMREAD]),
        .valid_i   (valid_q),
        .rd_i      (rd_q),
        .rs1_i     (Rs1_i),
        .rs2_i     (Rs2_i),
        .hazard_o  (hazard)
    );
`else
    assign hazard = 1'b0;
`endif

    always_comb begin
        if (stall_i) begin
            load_sel = LOAD_HOLD;
        end else if (flush_i || hazard || !valid_i) begin
            load_sel = LOAD_BUBBLE;
        end else begin
            load_sel = LOAD_NORMAL;
        end
    end

    always_comb begin
        valid_d   = valid_q;
        rs1data_d = rs1data_q;
        rs2data_d = rs2data_q;
        imm_d     = imm_q;
        funct_d   = funct_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        rd_d      = rd_q;
        ctrl_d    = ctrl_q;
        case (load_sel)
            LOAD_BUBBLE: begin
                valid_d   = 1'b0;
                rs1data_d = '0;
                rs2data_d = '0;
                imm_d     = '0;
                funct_d   = '0;
                rs1_d     = '0;
                rs2_d     = '0;
                rd_d      = '0;
                ctrl_d    = CTRL_NOP;
            end
            LOAD_NORMAL: begin
                valid_d   = 1'b1;
                rs1data_d = RS1data_i;
                rs2data_d = RS2data_i;
                imm_d     = imm_i;
                funct_d   = funct_i;
                rs1_d     = Rs1_i;
                rs2_d     = Rs2_i;
                rd_d      = Rd_i;
                ctrl_d    = ctrl_i;
                // x0 is never a real destination, so it must not look like a forwardable write
                ctrl_d[CTRL_REGWRITE] = ctrl_i[CTRL_REGWRITE] && (Rd_i != '0);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            valid_q   <= 1'b0;
            rs1data_q <= '0;
            rs2data_q <= '0;
            imm_q     <= '0;
            funct_q   <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            rd_q      <= '0;
            ctrl_q    <= CTRL_NOP;
        end else begin
            valid_q   <= valid_d;
            rs1data_q <= rs1data_d;
            rs2data_q <= rs2data_d;
            imm_q     <= imm_d;
            funct_q   <= funct_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            rd_q      <= rd_d;
            ctrl_q    <= ctrl_d;
        end
    end

    assign valid_o   = valid_q;
    assign RS1data_o = rs1data_q;
    assign RS2data_o = rs2data_q;
    assign imm_o     = imm_q;
    assign funct_o   = funct_q;
    assign Rs1_o     = rs1_q;
    assign Rs2_o     = rs2_q;
    assign Rd_o      = rd_q;
    assign ctrl_o    = ctrl_q;
    assign hazard_o  = hazard;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios then randomized traffic vs. a reference model.
module tb_id_ex_stage;

    localparam int unsigned XLEN = 32;
    localparam int unsigned RAW  = 5;

    logic            clk = 1'b0;
    logic            rst_i, stall_i, flush_i, valid_i;
    logic [XLEN-1:0] RS1data_i, RS2data_i, imm_i;
    logic [9:0]      funct_i;
    logic [RAW-1:0]  Rs1_i, Rs2_i, Rd_i;
    logic [7:0]      ctrl_i;
    logic            valid_o, hazard_o;
    logic [XLEN-1:0] RS1data_o, RS2data_o, imm_o;
    logic [9:0]      funct_o;
    logic [RAW-1:0]  Rs1_o, Rs2_o, Rd_o;
    logic [7:0]      ctrl_o;

    int total = 0;
    int bad   = 0;

    id_ex_stage #(.XLEN(XLEN), .RAW(RAW)) dut (
        .clk_i(clk), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
        .valid_i(valid_i), .RS1data_i(RS1data_i), .RS2data_i(RS2data_i),
        .imm_i(imm_i), .funct_i(funct_i), .Rs1_i(Rs1_i), .Rs2_i(Rs2_i),
        .Rd_i(Rd_i), .ctrl_i(ctrl_i), .valid_o(valid_o), .RS1data_o(RS1data_o),
        .RS2data_o(RS2data_o), .imm_o(imm_o), .funct_o(funct_o), .Rs1_o(Rs1_o),
        .Rs2_o(Rs2_o), .Rd_o(Rd_o), .ctrl_o(ctrl_o), .hazard_o(hazard_o)
    );

    always #5 clk = ~clk;

    // Reference model: the EX entry as the spec describes it.
    typedef struct {
        logic            valid;
        logic [XLEN-1:0] d1, d2, imm;
        logic [9:0]      funct;
        logic [RAW-1:0]  rs1, rs2, rd;
        logic [7:0]      ctrl;
    } entry_t;

    entry_t m;
    entry_t snap;

    function automatic entry_t empty_entry();
        entry_t e;
        e.valid = 1'b0; e.d1 = '0; e.d2 = '0; e.imm = '0; e.funct = '0;
        e.rs1 = '0; e.rs2 = '0; e.rd = '0; e.ctrl = 8'h00;
        return e;
    endfunction

    function automatic logic model_hazard();
`ifdef ID_EX_LOAD_USE_DETECT_EN
        return m.ctrl[5] && m.valid && (m.rd != 0) && ((m.rd == Rs1_i) || (m.rd == Rs2_i));
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_entry(input string tag, input entry_t e);
        chk({tag, ".valid"}, 64'(valid_o),   64'(e.valid));
        chk({tag, ".ctrl"},  64'(ctrl_o),    64'(e.ctrl));
        chk({tag, ".rd"},    64'(Rd_o),      64'(e.rd));
        chk({tag, ".rs1"},   64'(Rs1_o),     64'(e.rs1));
        chk({tag, ".rs2"},   64'(Rs2_o),     64'(e.rs2));
        chk({tag, ".d1"},    64'(RS1data_o), 64'(e.d1));
        chk({tag, ".d2"},    64'(RS2data_o), 64'(e.d2));
        chk({tag, ".imm"},   64'(imm_o),     64'(e.imm));
        chk({tag, ".funct"}, 64'(funct_o),   64'(e.funct));
    endtask

    // Check hazard before the edge, clock once, advance the model, check all outputs.
    task automatic cycle(input string tag);
        logic haz;
        #1;
        haz = model_hazard();
        chk({tag, ".hazard_pre"}, 64'(hazard_o), 64'(haz));
        @(posedge clk);
        if (!rst_i) begin
            m = empty_entry();
        end else if (stall_i) begin
            // entry kept as is
        end else if (flush_i || haz || !valid_i) begin
            m = empty_entry();
        end else begin
            m.valid = 1'b1; m.d1 = RS1data_i; m.d2 = RS2data_i; m.imm = imm_i;
            m.funct = funct_i; m.rs1 = Rs1_i; m.rs2 = Rs2_i; m.rd = Rd_i;
            m.ctrl = ctrl_i;
            if (Rd_i == 0) m.ctrl[7] = 1'b0;
        end
        #1;
        chk_entry(tag, m);
        chk({tag, ".hazard_post"}, 64'(hazard_o), 64'(model_hazard()));
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [7:0] c, input logic [RAW-1:0] rd,
                         input logic [RAW-1:0] s1, input logic [RAW-1:0] s2,
                         input logic [XLEN-1:0] d1);
        valid_i = v; ctrl_i = c; Rd_i = rd; Rs1_i = s1; Rs2_i = s2; RS1data_i = d1;
        RS2data_i = $urandom; imm_i = $urandom; funct_i = 10'($urandom);
    endtask

    initial begin
        m = empty_entry();
        rst_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
        drive(1'b1, 8'hE8, 5'd3, 5'd3, 5'd3, 32'hdead_beef);
        @(negedge clk);
        cycle("reset");
        chk("reset.valid_const", 64'(valid_o), 64'd0);
        chk("reset.ctrl_const",  64'(ctrl_o),  64'd0);
        rst_i = 1'b1;

        // Normal load
        drive(1'b1, 8'h88, 5'd5, 5'd1, 5'd2, 32'h1234);
        cycle("normal");
        chk("normal.ctrl_const", 64'(ctrl_o), 64'h88);
        chk("normal.rd_const",   64'(Rd_o),   64'd5);
        chk("normal.d1_const",   64'(RS1data_o), 64'h1234);

        // valid_i low becomes a bubble
        drive(1'b0, 8'h88, 5'd6, 5'd1, 5'd2, 32'h55);
        cycle("invalid_in");

        // x0 destination
        drive(1'b1, 8'h88, 5'd0, 5'd1, 5'd2, 32'h77);
        cycle("x0_alu");
        chk("x0_alu.ctrl_const", 64'(ctrl_o), 64'h08);
        drive(1'b1, 8'hE8, 5'd0, 5'd1, 5'd2, 32'h78);
        cycle("x0_lw");
        drive(1'b1, 8'h88, 5'd4, 5'd0, 5'd0, 32'h79);
        cycle("x0_use");

        // Load-use: lw x7, then an instruction reading x7 via Rs2
        drive(1'b1, 8'hE8, 5'd7, 5'd1, 5'd2, 32'h100);
        cycle("lw7");
        drive(1'b1, 8'h88, 5'd9, 5'd3, 5'd7, 32'h200);
        cycle("loaduse");
        chk("loaduse.hazard_clear", 64'(hazard_o), 64'd0);
        cycle("loaduse_retry");

        // Stall with flush for three cycles while Rs1_i toggles around the load's Rd
        drive(1'b1, 8'hE8, 5'd7, 5'd1, 5'd2, 32'h300);
        cycle("lw7b");
        snap = m;
        stall_i = 1'b1; flush_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'($urandom), 5'($urandom), (i == 1) ? 5'd4 : 5'd7, 5'd8, $urandom);
            cycle($sformatf("stall%0d", i));
            chk_entry($sformatf("stall%0d_snap", i), snap);
        end

        // Reset while the load is held: no edge yet, then one edge
        drive(1'b1, 8'h88, 5'd9, 5'd7, 5'd8, 32'h400);
        rst_i = 1'b0;
        #1;
        chk_entry("rst_noedge", m);
        chk("rst_noedge.hazard", 64'(hazard_o), 64'(model_hazard()));
        cycle("rst_edge");
        chk("rst_edge.hazard_const", 64'(hazard_o), 64'd0);
        rst_i = 1'b1; stall_i = 1'b0; flush_i = 1'b0;

        // Randomized traffic; small index range makes load-use pairs frequent
        for (int n = 0; n < 400; n++) begin
            logic [7:0] c;
            c = 8'($urandom);
            c[5] = ($urandom_range(0, 1) == 1);
            drive($urandom_range(0, 99) < 85, c, 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), $urandom);
            stall_i = $urandom_range(0, 99) < 15;
            flush_i = $urandom_range(0, 99) < 10;
            rst_i   = !($urandom_range(0, 99) < 2);
            cycle("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
